// File: rtl/divider_seq_if.sv
// rtl/divider_seq_if.sv - start/busy/done operand and result bundle for divider_seq
interface divider_seq_if #(
  parameter int N = 4
);
  logic           start;
  logic [2*N-1:0] dd;
  logic [N-1:0]   dv;
  logic [N-1:0]   q;
  logic [N-1:0]   r;
  logic           busy;
  logic           done;
  logic           dbz;
  logic           ovf;

  modport master (output start, dd, dv, input q, r, busy, done, dbz, ovf);
  modport slave  (input start, dd, dv, output q, r, busy, done, dbz, ovf);
endinterface

// File: rtl/divider_seq.sv
// rtl/divider_seq.sv - sequential restoring divider, one quotient bit per clock
// Macro DIV_OVF_DETECT_EN enables the quotient-overflow early exit; otherwise ovf is tied 0.
module divider_seq #(
  parameter int N = 4
) (
  input  logic        clk,
  input  logic        clr,
  divider_seq_if.slave bus
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state;
  logic [N:0]    rr;
  logic [N-1:0]  qq;
  logic [N-1:0]  dvr;
  logic [CW-1:0] cnt;
  logic [N-1:0]  q_reg;
  logic [N-1:0]  r_reg;
  logic          busy_reg;
  logic          done_reg;
  logic          dbz_reg;

  logic [N:0]    r_sh;
  logic [N+1:0]  diff;
  logic [N:0]    r_nx;
  logic [N-1:0]  q_nx;

  // Shift {R,Q} left, then trial-subtract; one extra sign bit keeps the compare exact.
  always_comb begin
    r_sh = {rr[N-1:0], qq[N-1]};
    diff = {1'b0, r_sh} - {2'b00, dvr};
    r_nx = r_sh;
    q_nx = {qq[N-2:0], 1'b0};
    if (!diff[N+1]) begin
      r_nx = diff[N:0];
      q_nx = {qq[N-2:0], 1'b1};
    end
  end

`ifdef DIV_OVF_DETECT_EN
  logic ovf_reg;
  assign bus.ovf = ovf_reg;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.q    = q_reg;
  assign bus.r    = r_reg;
  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.dbz  = dbz_reg;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      rr       <= '0;
      qq       <= '0;
      dvr      <= '0;
      cnt      <= '0;
      q_reg    <= '0;
      r_reg    <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
      dbz_reg  <= 1'b0;
`ifdef DIV_OVF_DETECT_EN
      ovf_reg  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            dvr     <= bus.dv;
            rr      <= {1'b0, bus.dd[2*N-1:N]};
            qq      <= bus.dd[N-1:0];
            dbz_reg <= 1'b0;
`ifdef DIV_OVF_DETECT_EN
            ovf_reg <= 1'b0;
`endif
            if (bus.dv == '0) begin
              state    <= DONE;
              done_reg <= 1'b1;
              q_reg    <= '1;
              r_reg    <= '0;
              dbz_reg  <= 1'b1;
`ifdef DIV_OVF_DETECT_EN
            end else if (bus.dd[2*N-1:N] >= bus.dv) begin
              state    <= DONE;
              done_reg <= 1'b1;
              q_reg    <= '1;
              r_reg    <= '0;
              ovf_reg  <= 1'b1;
`endif
            end else begin
              state    <= CALC;
              busy_reg <= 1'b1;
              cnt      <= CW'(N);
            end
          end
        end
        CALC: begin
          rr  <= r_nx;
          qq  <= q_nx;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state    <= DONE;
            busy_reg <= 1'b0;
            done_reg <= 1'b1;
            q_reg    <= q_nx;
            r_reg    <= r_nx[N-1:0];
          end
        end
        DONE: begin
          done_reg <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_divider_seq.sv
// tb/tb_divider_seq.sv - directed and exhaustive check of divider_seq against an arithmetic model
module tb_divider_seq;
  localparam int N = 4;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  divider_seq_if #(.N(N)) bus ();
  divider_seq #(.N(N)) dut (.clk(clk), .clr(clr), .bus(bus));

  typedef struct {
    int   t0;
    int   lat;
    logic fast;
    logic chk_qr;
    int   eq;
    int   er;
    int   edbz;
    int   eovf;
  } exp_t;

  exp_t pend[$];
  int   cyc = 0;
  int   cmp = 0;
  int   bad = 0;

  int   hq, hr, hdbz, hovf;
  logic hqr_valid;
  int   lq, lr, ldbz, lovf;

  exp_t me;
  int   el;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int ex);
    cmp++;
    if (act !== ex) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, ex, $time);
    end
  endtask

  // Expected result from plain integer division; quotient overflow means dd/dv needs more than N bits.
  function automatic exp_t model(input int dd, input int dv);
    exp_t e;
    e.t0 = 0; e.lat = N; e.fast = 1'b0; e.chk_qr = 1'b1;
    e.eq = 0; e.er = 0; e.edbz = 0; e.eovf = 0;
    if (dv == 0) begin
      e.fast = 1'b1; e.lat = 0; e.eq = (1 << N) - 1; e.edbz = 1;
    end else if (dd / dv >= (1 << N)) begin
`ifdef DIV_OVF_DETECT_EN
      e.fast = 1'b1; e.lat = 0; e.eq = (1 << N) - 1; e.eovf = 1;
`else
      e.chk_qr = 1'b0;
`endif
    end else begin
      e.eq = dd / dv;
      e.er = dd % dv;
    end
    return e;
  endfunction

  task automatic chk_hold();
    if (hqr_valid) begin
      chk("hold_q", int'(bus.q), hq);
      chk("hold_r", int'(bus.r), hr);
    end
    chk("hold_dbz", int'(bus.dbz), hdbz);
    chk("hold_ovf", int'(bus.ovf), hovf);
  endtask

  always @(negedge clk) begin
    if (!clr) begin
      if (bus.done) begin
        lq = int'(bus.q); lr = int'(bus.r); ldbz = int'(bus.dbz); lovf = int'(bus.ovf);
      end
      if (pend.size() > 0) begin
        me = pend[0];
        el = cyc - me.t0;
        chk("busy", int'(bus.busy), (!me.fast && el < N) ? 1 : 0);
        chk("done", int'(bus.done), (el == me.lat) ? 1 : 0);
        if (el >= me.lat) begin
          if (me.chk_qr) begin
            chk("q", int'(bus.q), me.eq);
            chk("r", int'(bus.r), me.er);
          end
          chk("dbz", int'(bus.dbz), me.edbz);
          chk("ovf", int'(bus.ovf), me.eovf);
          hq = me.eq; hr = me.er; hdbz = me.edbz; hovf = me.eovf;
          hqr_valid = me.chk_qr;
          void'(pend.pop_front());
        end else begin
          chk_hold();
        end
      end else begin
        chk("idle_busy", int'(bus.busy), 0);
        chk("idle_done", int'(bus.done), 0);
        chk_hold();
      end
    end
  end

  task automatic start_op(input int dd, input int dv);
    exp_t e;
    @(posedge clk); #2;
    bus.dd = (2*N)'(dd);
    bus.dv = N'(dv);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    e = model(dd, dv);
    e.t0 = cyc;
    pend.push_back(e);
    hdbz = 0; hovf = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 30 && pend.size() > 0; i++) @(posedge clk);
    if (pend.size() > 0) begin
      cmp++; bad++;
      $display("FAIL timeout: operation still pending, got %0d queued expected 0", pend.size());
      pend.delete();
    end
  endtask

  task automatic run_op(input int dd, input int dv);
    start_op(dd, dv);
    wait_idle();
  endtask

  initial begin
    clr = 1'b1;
    bus.start = 1'b0; bus.dd = '0; bus.dv = '0;
    hq = 0; hr = 0; hdbz = 0; hovf = 0; hqr_valid = 1'b1;
    lq = 0; lr = 0; ldbz = 0; lovf = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_q", int'(bus.q), 0);
    chk("rst_r", int'(bus.r), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_dbz", int'(bus.dbz), 0);
    chk("rst_ovf", int'(bus.ovf), 0);
    #1 clr = 1'b0;

    run_op(100, 7);
    chk("t1_q", lq, 14); chk("t1_r", lr, 2); chk("t1_dbz", ldbz, 0); chk("t1_ovf", lovf, 0);
    run_op(239, 15);
    chk("t2_q", lq, 15); chk("t2_r", lr, 14);
    run_op(0, 5);
    chk("t2b_q", lq, 0); chk("t2b_r", lr, 0);
    run_op(255, 0);
    chk("t3_q", lq, 15); chk("t3_r", lr, 0); chk("t3_dbz", ldbz, 1);
    run_op(200, 3);
`ifdef DIV_OVF_DETECT_EN
    chk("t4_q", lq, 15); chk("t4_r", lr, 0); chk("t4_ovf", lovf, 1);
`else
    chk("t4_ovf", lovf, 0);
`endif

    start_op(117, 9);
    @(posedge clk); #2;
    bus.dd = 8'd50; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_idle();
    chk("t5_q", lq, 13); chk("t5_r", lr, 0);
    run_op(50, 9);
    chk("t5b_q", lq, 5); chk("t5b_r", lr, 5);

    start_op(100, 7);
    @(posedge clk); #2;
    clr = 1'b1;
    pend.delete();
    hq = 0; hr = 0; hdbz = 0; hovf = 0; hqr_valid = 1'b1;
    #1;
    chk("t6_q", int'(bus.q), 0);
    chk("t6_r", int'(bus.r), 0);
    chk("t6_busy", int'(bus.busy), 0);
    chk("t6_done", int'(bus.done), 0);
    @(posedge clk); #2;
    clr = 1'b0;
    repeat (N + 2) @(posedge clk);
    run_op(100, 7);
    chk("t6b_q", lq, 14); chk("t6b_r", lr, 2);

    for (int a = 0; a < (1 << (2*N)); a++)
      for (int b = 0; b < (1 << N); b++)
        run_op(a, b);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
